// File: rtl/twiddle_rom_stream_bridge.sv
// twiddle_rom_stream_bridge: full-circle FFT twiddle source over a quarter-wave
// cosine ROM, folded by quadrant, conjugated for FFT, streamed through a FIFO.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_idx, req_shift         index j and stride; k = (j << shift) mod 2^FFT_N
//   req_ifft                   1: W = exp(+j*a), 0: W = exp(-j*a)
//   out_valid/out_ready        result handshake
//   out_real, out_imag         Re(W), Im(W), signed FFT_DW bits
//   twact, twa, twdr_cos       ROM port A (data one cycle after twact)
//   twact_b, twa_b, twdr_cos_b ROM port B (only with TWIDDLE_ROM_DP_EN)
//
// Build option TWIDDLE_ROM_DP_EN: dual-port ROM, 3-stage pipeline, one request
// per cycle. Without it: single-port ROM, 4-state FSM, one request per 3 cycles.
module twiddle_rom_stream_bridge #(
    parameter int FFT_N     = 10,
    parameter int FFT_DW    = 16,
    parameter int OUT_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [FFT_N-1:0]         req_idx,
    input  logic [$clog2(FFT_N)-1:0] req_shift,
    input  logic                     req_ifft,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FFT_DW-1:0]        out_real,
    output logic [FFT_DW-1:0]        out_imag,
    output logic                     twact,
    output logic [FFT_N-3:0]         twa,
    input  logic [FFT_DW-1:0]        twdr_cos
`ifdef TWIDDLE_ROM_DP_EN
    ,
    output logic                     twact_b,
    output logic [FFT_N-3:0]         twa_b,
    input  logic [FFT_DW-1:0]        twdr_cos_b
`endif
);

    localparam int AW = FFT_N - 2;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic              accept;
    logic              push;
    logic              pop;
    logic [FFT_DW-1:0] push_re;
    logic [FFT_DW-1:0] push_im;
    logic [FFT_N-1:0]  k_in;

    assign k_in   = req_idx << req_shift;
    assign accept = req_valid && req_ready;

    // Quadrant fold of (cos, sin) of the in-quadrant angle, then conjugate
    // for the forward transform.
    function automatic logic [2*FFT_DW-1:0] fold(
        input logic [1:0]        q,
        input logic [FFT_DW-1:0] c,
        input logic [FFT_DW-1:0] s,
        input logic              ifft
    );
        logic [FFT_DW-1:0] re;
        logic [FFT_DW-1:0] im;
        unique case (q)
            2'd0:    begin re = c;  im = s;  end
            2'd1:    begin re = -s; im = c;  end
            2'd2:    begin re = -c; im = -s; end
            default: begin re = s;  im = -c; end
        endcase
        return {re, ifft ? im : -im};
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- output FIFO ----------------
    logic [FFT_DW-1:0] re_mem_q [OUT_DEPTH];
    logic [FFT_DW-1:0] im_mem_q [OUT_DEPTH];
    logic [PW-1:0]     rd_q;
    logic [PW-1:0]     wr_q;
    logic [CW-1:0]     cnt_q;

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_real  = re_mem_q[rd_q];
    assign out_imag  = im_mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= next_ptr(wr_q);
            if (pop)  rd_q <= next_ptr(rd_q);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            re_mem_q[wr_q] <= push_re;
            im_mem_q[wr_q] <= push_im;
        end
    end

`ifdef TWIDDLE_ROM_DP_EN
    // ---------------- dual-port pipeline ----------------
    localparam int SW = CW + 2;

    logic              v1_q, v2_q, v3_q;
    logic [FFT_N-1:0]  k1_q, k2_q, k3_q;
    logic              i1_q, i2_q, i3_q;
    logic [FFT_DW-1:0] c3_q, s3_q;
    logic [SW-1:0]     credit;

    // Slots committed after this edge; a pop this cycle frees one.
    assign credit = SW'(cnt_q) + SW'(v1_q) + SW'(v2_q)
                  + SW'(v3_q) - SW'(pop);
    assign req_ready = !rst && (credit < SW'(OUT_DEPTH));

    assign twact   = v1_q && !rst;
    assign twact_b = v1_q && !rst;
    assign twa     = twact ? k1_q[AW-1:0] : '0;
    assign twa_b   = twact ? -k1_q[AW-1:0] : '0;

    assign push = v3_q && !rst;
    assign {push_re, push_im} = fold(k3_q[FFT_N-1 -: 2], c3_q, s3_q, i3_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            k1_q <= '0;
            k2_q <= '0;
            k3_q <= '0;
            i1_q <= 1'b0;
            i2_q <= 1'b0;
            i3_q <= 1'b0;
            c3_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                k1_q <= k_in;
                i1_q <= req_ifft;
            end
            v2_q <= v1_q;
            k2_q <= k1_q;
            i2_q <= i1_q;
            v3_q <= v2_q;
            k3_q <= k2_q;
            i3_q <= i2_q;
            c3_q <= twdr_cos;
            // r==0 addresses Q mod Q = 0 on port B; sin is exactly 0 there.
            s3_q <= (k2_q[AW-1:0] == '0) ? '0 : twdr_cos_b;
        end
    end
`else
    // ---------------- single-port FSM ----------------
    typedef enum logic [1:0] {IDLE, RD_COS, RD_SIN, WR} state_t;

    state_t            state_q, state_d;
    logic [FFT_N-1:0]  k_q;
    logic              ifft_q;
    logic [FFT_DW-1:0] cos_q;
    logic [AW-1:0]     r;
    logic [FFT_DW-1:0] sin_v;

    assign r     = k_q[AW-1:0];
    // The r==0 read returns rom[0]; sin(0) is forced to zero.
    assign sin_v = (r == '0) ? '0 : twdr_cos;

    assign req_ready = !rst &&
        ((state_q == IDLE && cnt_q < CW'(OUT_DEPTH)) ||
         (state_q == WR && cnt_q == '0));

    assign {push_re, push_im} = fold(k_q[FFT_N-1 -: 2], cos_q, sin_v, ifft_q);

    always_comb begin
        state_d = state_q;
        twact   = 1'b0;
        twa     = '0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RD_COS;
            end
            RD_COS: begin
                twact   = 1'b1;
                twa     = r;
                state_d = RD_SIN;
            end
            RD_SIN: begin
                twact   = 1'b1;
                twa     = -r;
                state_d = WR;
            end
            WR: begin
                push    = 1'b1;
                state_d = accept ? RD_COS : IDLE;
            end
        endcase
        if (rst) begin
            twact = 1'b0;
            twa   = '0;
            push  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            ifft_q  <= 1'b0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q    <= k_in;
                ifft_q <= req_ifft;
            end
            if (state_q == RD_SIN) cos_q <= twdr_cos;
        end
    end
`endif

endmodule

// File: tb/tb_twiddle_rom_stream_bridge.sv
// Testbench for twiddle_rom_stream_bridge: directed table vectors, back-pressure,
// reset abort and randomized traffic against a trigonometric reference model.
module tb_twiddle_rom_stream_bridge;

    localparam real PI = 3.14159265358979323846;
`ifdef TWIDDLE_ROM_DP_EN
    localparam int DEPTH  = 4;
    localparam int RD_PER = 1;
`else
    localparam int DEPTH  = 2;
    localparam int RD_PER = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_idx = '0;
    logic [3:0]  req_shift = '0;
    logic        req_ifft = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic        twact;
    logic [7:0]  twa;
    logic [15:0] twdr_cos;
`ifdef TWIDDLE_ROM_DP_EN
    logic        twact_b;
    logic [7:0]  twa_b;
    logic [15:0] twdr_cos_b;
`endif

    twiddle_rom_stream_bridge #(
        .FFT_N(10), .FFT_DW(16), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_shift(req_shift), .req_ifft(req_ifft),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .twact(twact), .twa(twa), .twdr_cos(twdr_cos)
`ifdef TWIDDLE_ROM_DP_EN
        , .twact_b(twact_b), .twa_b(twa_b), .twdr_cos_b(twdr_cos_b)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) if (twact) twdr_cos <= rom[twa];
`ifdef TWIDDLE_ROM_DP_EN
    always @(posedge clk) if (twact_b) twdr_cos_b <= rom[twa_b];
`endif

    int checks = 0;
    int errors = 0;
    int reads  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    typedef struct { int re; int im; } exp_t;

    // W = exp(-/+ j*2*pi*k/1024) scaled to 32767
    function automatic exp_t model(input int idx, input int sh, input bit ifft);
        exp_t e;
        int   k;
        real  a;
        k    = (idx << sh) & 1023;
        a    = 2.0 * PI * real'(k) / 1024.0;
        e.re = rnd(32767.0 * $cos(a));
        e.im = rnd(32767.0 * $sin(a));
        if (!ifft) e.im = -e.im;
        return e;
    endfunction

    exp_t mq[$];

    // Monitor: handshakes decided at the following rising edge.
    logic        hold_p = 1'b0;
    logic [31:0] hold_d = '0;
    always @(negedge clk) begin
        if (twact) reads++;
        if (hold_p) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'({out_real, out_imag} == hold_d), 1);
        end
        hold_p = out_valid && !out_ready && !rst;
        hold_d = {out_real, out_imag};
        if (rst) begin
            mq.delete();
        end else begin
            if (req_valid && req_ready)
                mq.push_back(model(int'(req_idx), int'(req_shift), req_ifft));
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    chk("unexpected_out", 0, 1);
                end else begin
                    exp_t e;
                    e = mq.pop_front();
                    chk("model_re", int'($signed(out_real)), e.re);
                    chk("model_im", int'($signed(out_imag)), e.im);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        req_idx   = 10'($urandom);
        req_shift = 4'($urandom_range(0, 15));
        req_ifft  = 1'($urandom);
    endtask

    task automatic send(input int idx, input int sh, input bit ifft);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_idx   = 10'(idx);
        req_shift = 4'(sh);
        req_ifft  = ifft;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        step();
        req_valid = 1'b0;
        rand_fields();
    endtask

    task automatic drain();
        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mq.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", mq.size(), 0);
        step();
    endtask

    typedef struct {
        int idx; int sh; bit ifft; int re; int im;
    } vec_t;

    initial begin
        vec_t tv[6];
        int   lat;
        bit   ok;
        bit   acc;
        int   n_acc;
        int   r0;
        int   first;
        int   last;
        int   nv;

        for (int a = 0; a < 256; a++)
            rom[a] = 16'(rnd(32767.0 * $cos(2.0 * PI * real'(a) / 1024.0)));

        tv[0] = '{0,   0, 1'b0,  32767,      0};
        tv[1] = '{256, 0, 1'b0,      0, -32767};
        tv[2] = '{384, 0, 1'b1, -23170,  23170};
        tv[3] = '{640, 0, 1'b0, -23170,  23170};
        tv[4] = '{1,   9, 1'b0, -32767,      0};
        tv[5] = '{3,   8, 1'b1,      0, -32767};

        // reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_twact", int'(twact), 0);
        chk("rst_twa", int'(twa), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(req_ready), 1);
        step();

        // directed table
        for (int i = 0; i < 6; i++) begin
            r0 = reads;
            send(tv[i].idx, tv[i].sh, tv[i].ifft);
            lat = 0;
            ok  = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    ok = 1'b1;
                    break;
                end
                lat++;
            end
            chk("tv_seen", int'(ok), 1);
            chk("tv_latency", lat, 3);
            chk("tv_re", int'($signed(out_real)), tv[i].re);
            chk("tv_im", int'($signed(out_imag)), tv[i].im);
            chk("tv_reads", reads - r0, RD_PER);
            step();
        end

        // back-pressure: only DEPTH accepted while the consumer stalls
        out_ready = 1'b0;
        n_acc     = 0;
        req_valid = 1'b1;
        rand_fields();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = req_ready;
            step();
            if (acc) begin
                n_acc++;
                rand_fields();
            end
        end
        chk("bp_accepted", n_acc, DEPTH);
        @(negedge clk);
        chk("bp_ready_low", int'(req_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        step();
        out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = req_ready;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_resume", int'(ok), 1);
        req_valid = 1'b0;
        drain();

        // reset abort with one entry waiting in the FIFO
        out_ready = 1'b0;
        send(100, 0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        step();
        send(200, 1, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_low", int'(req_ready), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_twact", int'(twact), 0);
        step();
        @(negedge clk);
        chk("abort_idle_twact", int'(twact), 0);
        chk("abort_idle_valid", int'(out_valid), 0);
        step();
        out_ready = 1'b1;
        send(tv[2].idx, tv[2].sh, tv[2].ifft);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_after_seen", int'(ok), 1);
        chk("abort_after_re", int'($signed(out_real)), tv[2].re);
        chk("abort_after_im", int'($signed(out_imag)), tv[2].im);
        step();
        drain();

`ifdef TWIDDLE_ROM_DP_EN
        // one request per cycle, outputs back to back
        out_ready = 1'b1;
        req_valid = 1'b1;
        rand_fields();
        first = -1;
        last  = -1;
        nv    = 0;
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (m < 16) chk("dp_ready", int'(req_ready), 1);
            if (out_valid) begin
                if (first < 0) first = m;
                last = m;
                nv++;
            end
            step();
            if (m < 15) rand_fields();
            else req_valid = 1'b0;
        end
        chk("dp_first", first, 4);
        chk("dp_last", last, 19);
        chk("dp_count", nv, 16);
        drain();
`else
        first = 0;
        last  = 0;
        nv    = 0;
`endif

        // randomized traffic
        n_acc     = 0;
        req_valid = 1'b0;
        for (int c = 0; c < 3000 && n_acc < 60; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            step();
            if (acc) n_acc++;
            if (acc || !req_valid) begin
                req_valid = ($urandom % 3) != 0;
                rand_fields();
            end
            out_ready = ($urandom % 4) != 0;
        end
        chk("rand_accepted", n_acc, 60);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
